// File: rtl/seven_segment_value_display.sv
// Decimal HEX-display driver: double-dabble conversion plus 7-seg encoding.
// Optional SIGNED_DISPLAY_EN: two's-complement input shown with a minus sign.
module seven_segment_value_display #(
  parameter  int DISPLAYS    = 6,
  parameter  int WIDTH       = 20,
  localparam int DISPLAY_MSB = (8*DISPLAYS)-1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   value,
  input  logic               load,
  output logic               ready,
  output logic               done,
  output logic               overflow,
  output logic [DISPLAY_MSB:0] display
);

  localparam int BW = 4*DISPLAYS;
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
`ifdef SIGNED_DISPLAY_EN
    NEGATE  = 2'd1,
`endif
    CONVERT = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 neg_q, neg_d;
  logic [DISPLAY_MSB:0] disp_q, disp_d;
  logic                 oflag_q, oflag_d;
  logic                 done_q, done_d;

  logic [BW-1:0]        adj;
  logic [BW-1:0]        bcd_sh;
  logic [WIDTH-1:0]     shift_sh;
  logic                 carry;
  logic [DISPLAYS-1:0]  blank;
  logic [DISPLAYS-1:0]  sign_pos;
  logic                 zero_run;
  logic                 ovf_all;
  logic [DISPLAY_MSB:0] enc;

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  // One double-dabble step: add 3 to digits >= 5, then shift left.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DISPLAYS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {carry, bcd_sh, shift_sh} = {adj, shift_q, 1'b0};
  end

  always_comb begin
    ovf_all  = ovf_q | (neg_q & (|bcd_q[BW-1 -: 4]));
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DISPLAYS-1; i > 0; i--) begin
      zero_run = zero_run & (bcd_q[4*i +: 4] == 4'd0);
      blank[i] = zero_run;
    end
    // Sign goes in the first blanked position left of the leading digit.
    sign_pos = blank & ((~blank) << 1);
    enc = '1;
    for (int i = 0; i < DISPLAYS; i++) begin
      if (ovf_all)
        enc[8*i +: 8] = 8'hBF;
      else if (blank[i])
        enc[8*i +: 8] = (neg_q && sign_pos[i]) ? 8'hBF : 8'hFF;
      else
        enc[8*i +: 8] = seg(bcd_q[4*i +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    disp_d  = disp_q;
    oflag_d = oflag_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = value;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef SIGNED_DISPLAY_EN
          neg_d   = value[WIDTH-1];
          state_d = NEGATE;
`else
          neg_d   = 1'b0;
          state_d = CONVERT;
`endif
        end
      end
`ifdef SIGNED_DISPLAY_EN
      NEGATE: begin
        if (neg_q)
          shift_d = -shift_q;
        state_d = CONVERT;
      end
`endif
      CONVERT: begin
        shift_d = shift_sh;
        bcd_d   = bcd_sh;
        ovf_d   = ovf_q | carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1))
          state_d = UPDATE;
      end
      UPDATE: begin
        disp_d  = enc;
        oflag_d = ovf_all;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      disp_q  <= '1;
      oflag_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      disp_q  <= disp_d;
      oflag_q <= oflag_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign overflow = oflag_q;
  assign display  = disp_q;

endmodule

// File: tb/tb_seven_segment_value_display.sv
// Directed bench for seven_segment_value_display (DISPLAYS=6, WIDTH=20).
// Signed cases run when SIGNED_DISPLAY_EN is defined for the build.
module tb_seven_segment_value_display;

`ifdef SIGNED_DISPLAY_EN
  localparam int LAT = 22;
`else
  localparam int LAT = 21;
`endif

  logic        clk;
  logic        rst_n;
  logic [19:0] value;
  logic        load;
  logic        ready;
  logic        done;
  logic        overflow;
  logic [47:0] display;

  int checks = 0;
  int errors = 0;

  seven_segment_value_display #(.DISPLAYS(6), .WIDTH(20)) dut (
    .clock   (clk),
    .reset   (rst_n),
    .value   (value),
    .load    (load),
    .ready   (ready),
    .done    (done),
    .overflow(overflow),
    .display (display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // poke>0: pulse load with value 7 at that cycle while busy.
  task automatic convert(input string tag, input logic [19:0] v,
                         input logic [47:0] exp_d, input logic exp_o,
                         input int poke);
    int n;
    bit seen;
    @(posedge clk); #1;
    chk({tag, "_rdy0"}, ready, 1'b1);
    value = v;
    load  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk({tag, "_busy"}, ready, 1'b0);
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (poke > 0 && n == poke) begin
        value = 20'd7;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      if (done) seen = 1;
    end
    load = 1'b0;
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_disp"}, display, exp_d);
    chk({tag, "_ovf"}, overflow, exp_o);
    chk({tag, "_rdy1"}, ready, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 1'b0);
  endtask

  initial begin
    int n;
    int t;
    bit seen;
    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_disp", display, 48'hFFFFFFFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    convert("zero", 20'd0,      48'hFFFFFFFFFFC0, 1'b0, 0);
    convert("v123", 20'd123456, 48'hF9A4B0999282, 1'b0, 0);
    convert("v42",  20'd42,     48'hFFFFFFFF99A4, 1'b0, 0);
    convert("busy", 20'd42,     48'hFFFFFFFF99A4, 1'b0, 5);
`ifdef SIGNED_DISPLAY_EN
    convert("pmax", 20'd524287, 48'h92A499A480F8, 1'b0, 0);
    convert("m42",  20'hFFFD6,  48'hFFFFFFBF99A4, 1'b0, 0);
    convert("m99k", 20'hE7961,  48'hBF9090909090, 1'b0, 0);
    convert("m100k", 20'hE7960, 48'hBFBFBFBFBFBF, 1'b1, 0);
    convert("mmin", 20'h80000,  48'hBFBFBFBFBFBF, 1'b1, 0);
`else
    convert("v999", 20'd999999, 48'h909090909090, 1'b0, 0);
    convert("v1M",  20'd1000000, 48'hBFBFBFBFBFBF, 1'b1, 0);
    convert("v100k", 20'd100000, 48'hF9C0C0C0C0C0, 1'b0, 0);
    convert("vmax", 20'hFFFFF,  48'hBFBFBFBFBFBF, 1'b1, 0);
`endif
    convert("clr", 20'd42,      48'hFFFFFFFF99A4, 1'b0, 0);

    // load held high: two back-to-back conversions.
    @(posedge clk); #1;
    value = 20'd5;
    load  = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
    end
    chk("b2b_first", seen, 1'b1);
    t = 0;
    seen = 0;
    while (!seen && t < 100) begin
      @(posedge clk); #1;
      t++;
      if (done) seen = 1;
    end
    load = 1'b0;
    chk("b2b_period", t, LAT + 1);
    chk("b2b_disp", display, 48'hFFFFFFFFFF92);

    // Reset in the middle of a conversion.
    @(posedge clk); #1;
    value = 20'd123456;
    load  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_disp", display, 48'hFFFFFFFFFFFF);
    chk("abort_rdy", ready, 1'b1);
    chk("abort_ovf", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("abort_nodone", seen, 1'b0);
    chk("abort_hold", display, 48'hFFFFFFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
